// File: rtl/tlc_ctrl.sv
// Two-road traffic light control FSM: programs absolute compare targets on done_val and steps
// phases on cnt_done. Define TLC_PED_WALK_EN to add the pedestrian walk phase.
module tlc_ctrl #(
    parameter int unsigned NS_GREEN_T = 20,
    parameter int unsigned EW_GREEN_T = 12,
    parameter int unsigned YELLOW_T   = 4,
    parameter int unsigned RED_T      = 2,
    parameter int unsigned PED_T      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cnt_done,
    input  logic       ew_req,
`ifdef TLC_PED_WALK_EN
    input  logic       ped_req,
    output logic       ped_walk,
`endif
    output logic [4:0] done_val,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light
);

    localparam logic [2:0] Red = 3'b100;
    localparam logic [2:0] Yel = 3'b010;
    localparam logic [2:0] Grn = 3'b001;

    // Target is shadow + D - 1, so keep D - 1 per phase.
    localparam logic [4:0] NsGreenM1 = 5'(NS_GREEN_T - 1);
    localparam logic [4:0] EwGreenM1 = 5'(EW_GREEN_T - 1);
    localparam logic [4:0] YellowM1  = 5'(YELLOW_T - 1);
    localparam logic [4:0] RedM1     = 5'(RED_T - 1);
    localparam logic [4:0] PedM1     = 5'(PED_T - 1);

    typedef enum logic [2:0] {
        StInit     = 3'd0,
        StAllRed2  = 3'd1,
        StNsGreen  = 3'd2,
        StNsYellow = 3'd3,
        StAllRed1  = 3'd4,
        StEwGreen  = 3'd5,
        StEwYellow = 3'd6
`ifdef TLC_PED_WALK_EN
        , StPedWalk = 3'd7
`endif
    } state_e;

    state_e     state_q, state_d;
    logic [4:0] shadow_q;
    logic [4:0] dur_m1;
    logic       enter, go, entry_q;
    logic       ew_flag_q, ew_flag_d;
    logic       leave_ns;
    logic [2:0] ns_d, ew_d;

`ifdef TLC_PED_WALK_EN
    logic ped_flag_q, ped_flag_d, ped_ret_ns_q, walk_d;
    assign leave_ns = ew_flag_q | ped_flag_q;
`else
    assign leave_ns = ew_flag_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StInit;
            shadow_q  <= '0;
            done_val  <= '0;
            ns_light  <= Red;
            ew_light  <= Red;
            ew_flag_q <= 1'b0;
            entry_q   <= 1'b1;
`ifdef TLC_PED_WALK_EN
            ped_flag_q   <= 1'b0;
            ped_ret_ns_q <= 1'b0;
            ped_walk     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_q + 5'd1;
            ns_light  <= ns_d;
            ew_light  <= ew_d;
            ew_flag_q <= ew_flag_d;
            entry_q   <= enter;
            if (enter) begin
                done_val <= shadow_q + dur_m1;
            end
`ifdef TLC_PED_WALK_EN
            ped_flag_q <= ped_flag_d;
            ped_walk   <= walk_d;
            if (enter && state_d == StPedWalk) begin
                ped_ret_ns_q <= (state_q == StNsYellow);
            end
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        enter   = 1'b0;
        // The first cycle of every phase sees a stale match, so it never counts.
        go      = cnt_done & ~entry_q;
        case (state_q)
            StInit: begin
                state_d = StAllRed2;
                enter   = 1'b1;
            end
            StAllRed2: if (go) begin
                state_d = StNsGreen;
                enter   = 1'b1;
            end
            StNsGreen: if (go) begin
                state_d = leave_ns ? StNsYellow : StNsGreen;
                enter   = 1'b1;
            end
            StNsYellow: if (go) begin
                state_d = StAllRed1;
`ifdef TLC_PED_WALK_EN
                if (ped_flag_q) state_d = StPedWalk;
`endif
                enter = 1'b1;
            end
            StAllRed1: if (go) begin
                state_d = StEwGreen;
                enter   = 1'b1;
            end
            StEwGreen: if (go) begin
                state_d = StEwYellow;
                enter   = 1'b1;
            end
            StEwYellow: if (go) begin
                state_d = StAllRed2;
`ifdef TLC_PED_WALK_EN
                if (ped_flag_q) state_d = StPedWalk;
`endif
                enter = 1'b1;
            end
`ifdef TLC_PED_WALK_EN
            StPedWalk: if (go) begin
                state_d = ped_ret_ns_q ? StAllRed1 : StAllRed2;
                enter   = 1'b1;
            end
`endif
            default: begin
                state_d = StAllRed2;
                enter   = 1'b1;
            end
        endcase

        case (state_d)
            StNsGreen:              dur_m1 = NsGreenM1;
            StEwGreen:              dur_m1 = EwGreenM1;
            StNsYellow, StEwYellow: dur_m1 = YellowM1;
            StAllRed1, StAllRed2:   dur_m1 = RedM1;
            default:                dur_m1 = PedM1;
        endcase

        // A clear on EW green entry wins over a same-cycle request.
        ew_flag_d = (ew_flag_q | ew_req) & ~(enter & (state_d == StEwGreen));
`ifdef TLC_PED_WALK_EN
        ped_flag_d = (ped_flag_q | ped_req) & ~(enter & (state_d == StPedWalk));
`endif
    end

    always_comb begin
        ns_d = Red;
        ew_d = Red;
`ifdef TLC_PED_WALK_EN
        walk_d = 1'b0;
`endif
        case (state_d)
            StNsGreen:  ns_d = Grn;
            StNsYellow: ns_d = Yel;
            StEwGreen:  ew_d = Grn;
            StEwYellow: ew_d = Yel;
`ifdef TLC_PED_WALK_EN
            StPedWalk:  walk_d = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tlc_ctrl.sv
// Bench for tlc_ctrl: constant vector table, hand sequences for corner cases and random
// ew_req (and ped_req with TLC_PED_WALK_EN) against a phase/duration reference model.
module tb_tlc_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ew_req = 1'b0;
    logic       ped_req = 1'b0;
    logic       force_done = 1'b0;
    logic       cnt_done, cnt_done_w;
    logic [4:0] done_val, done_val_w;
    logic [2:0] ns_light, ew_light, ns_w, ew_w;
    logic       ped_walk, ped_walk_w;
    logic [4:0] cnt;
    logic       dp_done, dp_done_w;

    always #5 clk = ~clk;

    tlc_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .cnt_done (cnt_done),
        .ew_req   (ew_req),
`ifdef TLC_PED_WALK_EN
        .ped_req  (ped_req),
        .ped_walk (ped_walk),
`endif
        .done_val (done_val),
        .ns_light (ns_light),
        .ew_light (ew_light)
    );

    // Long all-red so the first NS green entry sees shadow_pre = 28 (target wraps).
    tlc_ctrl #(.RED_T(28)) dut_w (
        .clk      (clk),
        .rst      (rst),
        .cnt_done (cnt_done_w),
        .ew_req   (ew_req),
`ifdef TLC_PED_WALK_EN
        .ped_req  (ped_req),
        .ped_walk (ped_walk_w),
`endif
        .done_val (done_val_w),
        .ns_light (ns_w),
        .ew_light (ew_w)
    );

`ifndef TLC_PED_WALK_EN
    assign ped_walk   = 1'b0;
    assign ped_walk_w = 1'b0;
`endif

    // Counter datapath: free-running counter and registered match pulse.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            dp_done   <= 1'b0;
            dp_done_w <= 1'b0;
        end else begin
            cnt       <= cnt + 5'd1;
            dp_done   <= (cnt == done_val);
            dp_done_w <= (cnt == done_val_w);
        end
    end
    assign cnt_done   = dp_done | force_done;
    assign cnt_done_w = dp_done_w;

    // Reference model: phase plus remaining cycles; absolute target from a cycle count.
    typedef enum int {PInit, PAr2, PNsg, PNsy, PAr1, PEwg, PEwy, PPed} phase_e;
    phase_e m_phase;
    int     m_left, m_shadow, m_done;
    bit     m_ew, m_ped, m_ret1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int         edge_n;
        logic [2:0] ns;
        logic [2:0] ew;
        logic [4:0] dv;
    } vec_t;
    vec_t tbl[8];

    function automatic int dur(input phase_e p);
        case (p)
            PNsg:       return 20;
            PEwg:       return 12;
            PNsy, PEwy: return 4;
            PPed:       return 8;
            default:    return 2;
        endcase
    endfunction

    function automatic logic [2:0] exp_ns(input phase_e p);
        case (p)
            PNsg:    return 3'b001;
            PNsy:    return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] exp_ew(input phase_e p);
        case (p)
            PEwg:    return 3'b001;
            PEwy:    return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    task automatic model_reset();
        m_phase  = PInit;
        m_left   = 0;
        m_shadow = 0;
        m_done   = 0;
        m_ew     = 1'b0;
        m_ped    = 1'b0;
        m_ret1   = 1'b0;
    endtask

    task automatic model_step();
        phase_e nxt;
        bit     ent;
        nxt = m_phase;
        ent = 1'b0;
        if (m_phase == PInit) begin
            nxt = PAr2;
            ent = 1'b1;
        end else begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                ent = 1'b1;
                case (m_phase)
                    PAr2: nxt = PNsg;
                    PNsg: nxt = (m_ew || m_ped) ? PNsy : PNsg;
                    PNsy: begin nxt = m_ped ? PPed : PAr1; m_ret1 = 1'b1; end
                    PAr1: nxt = PEwg;
                    PEwg: nxt = PEwy;
                    PEwy: begin nxt = m_ped ? PPed : PAr2; m_ret1 = 1'b0; end
                    PPed: nxt = m_ret1 ? PAr1 : PAr2;
                    default: nxt = PAr2;
                endcase
            end
        end
        if (ent) begin
            m_left = dur(nxt);
            m_done = (m_shadow + dur(nxt) - 1) % 32;
        end
        m_ew     = (m_ew || ew_req) && !(ent && nxt == PEwg);
        m_ped    = (m_ped || ped_req) && !(ent && nxt == PPed);
        m_shadow = (m_shadow + 1) % 32;
        m_phase  = nxt;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_step();
        #1;
    endtask

    task automatic check_model();
        chk("model_ns", 32'(ns_light), 32'(exp_ns(m_phase)));
        chk("model_ew", 32'(ew_light), 32'(exp_ew(m_phase)));
        chk("model_done_val", 32'(done_val), 32'(m_done));
        chk("model_ped_walk", 32'(ped_walk), 32'(m_phase == PPed));
        chk("safety", 32'(ns_light != 3'b100 && ew_light != 3'b100), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ew_req = 1'b0;
        ped_req = 1'b0;
        force_done = 1'b0;
        model_reset();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_table(input bit force_first);
        int k;
        k = 0;
        ew_req = 1'b1;
        for (int e = 1; e <= 47; e++) begin
            force_done = force_first && (e <= 2);
            tick();
            check_model();
            if (k < 8 && tbl[k].edge_n == e) begin
                chk("tbl_ns", 32'(ns_light), 32'(tbl[k].ns));
                chk("tbl_ew", 32'(ew_light), 32'(tbl[k].ew));
                chk("tbl_done_val", 32'(done_val), 32'(tbl[k].dv));
                k++;
            end
        end
        force_done = 1'b0;
        chk("tbl_all_seen", 32'(k), 32'd8);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        // done_val = (edge - 1 + D - 1) mod 32 at each phase entry edge.
        tbl[0] = '{1,  3'b100, 3'b100, 5'd1};
        tbl[1] = '{3,  3'b001, 3'b100, 5'd21};
        tbl[2] = '{23, 3'b010, 3'b100, 5'd25};
        tbl[3] = '{27, 3'b100, 3'b100, 5'd27};
        tbl[4] = '{29, 3'b100, 3'b001, 5'd7};
        tbl[5] = '{41, 3'b100, 3'b010, 5'd11};
        tbl[6] = '{45, 3'b100, 3'b100, 5'd13};
        tbl[7] = '{47, 3'b001, 3'b100, 5'd1};

        model_reset();
        #1 rst = 1'b1;
        #2;
        chk("reset_ns", 32'(ns_light), 32'(3'b100));
        chk("reset_ew", 32'(ew_light), 32'(3'b100));
        chk("reset_done_val", 32'(done_val), 32'd0);
        chk("reset_ew_flag", 32'(dut.ew_flag_q), 32'd0);
        chk("reset_ped_walk", 32'(ped_walk), 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // Full cycle with a waiting EW vehicle.
        run_table(1'b0);

        // No EW demand: NS green keeps re-arming, EW stays red.
        do_reset();
        for (int i = 0; i < 200; i++) begin
            tick();
            check_model();
            chk("ew_stays_red", 32'(ew_light), 32'(3'b100));
        end

        // Single request pulse; a request on the EW green entry edge still clears.
        do_reset();
        for (int e = 1; e <= 30; e++) begin
            ew_req = (e == 10 || e == 29);
            tick();
            check_model();
            if (e == 10) chk("flag_set", 32'(dut.ew_flag_q), 32'd1);
            if (e == 22) chk("ns_green_held", 32'(ns_light), 32'(3'b001));
            if (e == 23) chk("ns_yellow_at_23", 32'(ns_light), 32'(3'b010));
            if (e == 29) chk("flag_clear_on_ewg", 32'(dut.ew_flag_q), 32'd0);
            if (e == 29) chk("ew_green_at_29", 32'(ew_light), 32'(3'b001));
        end
        ew_req = 1'b0;

        // Target wrap on the long-all-red instance.
        do_reset();
        ew_req = 1'b1;
        for (int e = 1; e <= 50; e++) begin
            tick();
            check_model();
            if (e == 28) chk("wrap_pre_ns", 32'(ns_w), 32'(3'b100));
            if (e == 29) chk("wrap_done_val", 32'(done_val_w), 32'd15);
            if (e == 29) chk("wrap_ns_green", 32'(ns_w), 32'(3'b001));
            if (e == 48) chk("wrap_ns_still_green", 32'(ns_w), 32'(3'b001));
            if (e == 49) chk("wrap_ns_yellow", 32'(ns_w), 32'(3'b010));
        end

        // Reset mid EW green, then a forced match right after release.
        do_reset();
        ew_req = 1'b1;
        for (int e = 1; e <= 35; e++) begin
            tick();
            check_model();
        end
        chk("pre_reset_ew_green", 32'(ew_light), 32'(3'b001));
        rst = 1'b1;
        #1;
        chk("async_reset_ns", 32'(ns_light), 32'(3'b100));
        chk("async_reset_ew", 32'(ew_light), 32'(3'b100));
        chk("async_reset_done_val", 32'(done_val), 32'd0);
        model_reset();
        tick();
        rst = 1'b0;
        run_table(1'b1);

`ifdef TLC_PED_WALK_EN
        // Pedestrian request during EW green.
        do_reset();
        ew_req = 1'b1;
        for (int e = 1; e <= 56; e++) begin
            ped_req = (e == 35);
            tick();
            check_model();
            if (e == 45) chk("ped_walk_on", 32'(ped_walk), 32'd1);
            if (e == 52) chk("ped_walk_last", 32'(ped_walk), 32'd1);
            if (e == 53) chk("ped_walk_off", 32'(ped_walk), 32'd0);
            if (e == 53) chk("ped_then_allred", 32'(ns_light), 32'(3'b100));
            if (e == 55) chk("ped_then_ns_green", 32'(ns_light), 32'(3'b001));
        end
        ped_req = 1'b0;
`endif

        // Random demand against the model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            ew_req = ($urandom_range(0, 7) == 0);
`ifdef TLC_PED_WALK_EN
            ped_req = ($urandom_range(0, 15) == 0);
`endif
            tick();
            check_model();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
